hs_stream_arbiter: RTL and testbench

Shares one 64-bit `ap_vld`/`ap_ack` handshake port between NUM_IN AXI-Stream requesters. It sits between several accelerator-side stream producers and a single HLS handshake consumer. Requesters are served round-robin, and each accepted word is held in an output register until the consumer acknowledges it. A grant can optionally be held for a whole packet, up to `tlast`.

---
 rtl/hs_stream_arbiter_if.sv | 40 ++++
 rtl/hs_stream_arbiter.sv | 168 ++++++++++++++++
 tb/tb_hs_stream_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/hs_stream_arbiter_if.sv
// Requester-side AXI-Stream bundle and consumer-side ap_vld/ap_ack handshake for hs_stream_arbiter.
// The arbiter connects through the slave modport; the surrounding fabric drives the master side.
interface hs_stream_arbiter_if #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned ID_W   = 3
);
    logic [NUM_IN*64-1:0] in_tdata;
    logic [NUM_IN-1:0]    in_tvalid;
    logic [NUM_IN-1:0]    in_tlast;
    logic [NUM_IN-1:0]    in_tready;
    logic [63:0]          out_hs;
    logic                 out_hs_ap_vld;
    logic                 out_hs_ap_ack;
    logic [ID_W-1:0]      out_id;
    logic                 out_last;

    modport slave (
        input  in_tdata,
        input  in_tvalid,
        input  in_tlast,
        input  out_hs_ap_ack,
        output in_tready,
        output out_hs,
        output out_hs_ap_vld,
        output out_id,
        output out_last
    );

    modport master (
        output in_tdata,
        output in_tvalid,
        output in_tlast,
        output out_hs_ap_ack,
        input  in_tready,
        input  out_hs,
        input  out_hs_ap_vld,
        input  out_id,
        input  out_last
    );
endinterface

// File: rtl/hs_stream_arbiter.sv
// Round-robin arbiter folding NUM_IN AXI-Stream requesters onto one registered ap_vld/ap_ack port.
// Define HS_ARB_PKT_LOCK_EN to hold a grant from a packet's first word until its tlast word is acked.
module hs_stream_arbiter #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned ID_W   = 3
) (
    input  logic               aclk,
    input  logic               aresetn,
    hs_stream_arbiter_if.slave io_arb
);

`ifdef HS_ARB_PKT_LOCK_EN
    typedef enum logic [1:0] {StIdle = 2'd0, StWaitAck = 2'd1, StLocked = 2'd2} state_e;
`else
    typedef enum logic [1:0] {StIdle = 2'd0, StWaitAck = 2'd1} state_e;
`endif

    state_e            r_state;
    state_e            w_state_nxt;
    logic [63:0]       r_out_hs;
    logic [ID_W-1:0]   r_out_id;
    logic              r_out_last;
    logic [ID_W-1:0]   r_last_grant;

    logic [ID_W-1:0]   w_pick;
    logic [ID_W-1:0]   w_sel;
    logic [NUM_IN-1:0] w_pick_onehot;
    logic [NUM_IN-1:0] w_last_onehot;
    logic [NUM_IN-1:0] w_tready;
    logic [63:0]       w_sel_data;
    logic              w_sel_last;
    logic              w_capture;

    // Two passes: indices above last_grant first, then wrap to the low indices.
    function automatic logic [ID_W-1:0] rr_pick(input logic [ID_W-1:0] last,
                                                input logic [NUM_IN-1:0] valid);
        logic [ID_W-1:0] pick;
        logic            found;
        pick  = last;
        found = 1'b0;
        for (int unsigned j = 0; j < NUM_IN; j++) begin
            if (!found && valid[j] && (ID_W'(j) > last)) begin
                pick  = ID_W'(j);
                found = 1'b1;
            end
        end
        for (int unsigned j = 0; j < NUM_IN; j++) begin
            if (!found && valid[j] && (ID_W'(j) <= last)) begin
                pick  = ID_W'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [NUM_IN-1:0] to_onehot(input logic [ID_W-1:0] idx);
        logic [NUM_IN-1:0] oh;
        oh = '0;
        for (int unsigned j = 0; j < NUM_IN; j++) begin
            oh[j] = (ID_W'(j) == idx);
        end
        return oh;
    endfunction

    assign w_pick        = rr_pick(r_last_grant, io_arb.in_tvalid);
    assign w_pick_onehot = to_onehot(w_pick);
    assign w_last_onehot = to_onehot(r_last_grant);

`ifdef HS_ARB_PKT_LOCK_EN
    assign w_sel = (r_state == StLocked) ? r_last_grant : w_pick;
`else
    assign w_sel = w_pick;
`endif

    always_comb begin
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int unsigned j = 0; j < NUM_IN; j++) begin
            if (ID_W'(j) == w_sel) begin
                w_sel_data = io_arb.in_tdata[64*j +: 64];
                w_sel_last = io_arb.in_tlast[j];
            end
        end
    end

    assign w_capture = |(io_arb.in_tvalid & w_tready);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (w_capture) begin
                    w_state_nxt = StWaitAck;
                end
            end
            StWaitAck: begin
                if (io_arb.out_hs_ap_ack) begin
`ifdef HS_ARB_PKT_LOCK_EN
                    w_state_nxt = r_out_last ? StIdle : StLocked;
`else
                    w_state_nxt = StIdle;
`endif
                end
            end
`ifdef HS_ARB_PKT_LOCK_EN
            StLocked: begin
                if (w_capture) begin
                    w_state_nxt = StWaitAck;
                end
            end
`endif
            default: w_state_nxt = StIdle;
        endcase
    end

    // Ready is gated by reset so no requester sees a handshake while aresetn is low.
    always_comb begin
        w_tready = '0;
        case (r_state)
            StIdle: begin
                if (|io_arb.in_tvalid) begin
                    w_tready = w_pick_onehot;
                end
            end
`ifdef HS_ARB_PKT_LOCK_EN
            StLocked: w_tready = w_last_onehot;
`endif
            default: w_tready = '0;
        endcase
        if (!aresetn) begin
            w_tready = '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_out_hs     <= '0;
            r_out_id     <= '0;
            r_out_last   <= 1'b0;
            r_last_grant <= ID_W'(NUM_IN - 1);
        end else if (w_capture) begin
            r_out_hs     <= w_sel_data;
            r_out_id     <= w_sel;
            r_out_last   <= w_sel_last;
            r_last_grant <= w_sel;
        end
    end

`ifndef HS_ARB_PKT_LOCK_EN
    logic w_unused;
    assign w_unused = |w_last_onehot;
`endif

    assign io_arb.in_tready     = w_tready;
    assign io_arb.out_hs        = r_out_hs;
    assign io_arb.out_hs_ap_vld = (r_state == StWaitAck);
    assign io_arb.out_id        = r_out_id;
    assign io_arb.out_last      = r_out_last;

endmodule

// File: tb/tb_hs_stream_arbiter.sv
// Directed bench for hs_stream_arbiter: per-requester word sources and an ack-driven consumer log.
// Lock-sequence expectations follow HS_ARB_PKT_LOCK_EN.
module tb_hs_stream_arbiter;
    localparam int unsigned NUM_IN = 4;
    localparam int unsigned ID_W   = 3;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    hs_stream_arbiter_if #(.NUM_IN(NUM_IN), .ID_W(ID_W)) arb ();

    hs_stream_arbiter #(
        .NUM_IN(NUM_IN),
        .ID_W  (ID_W)
    ) u_dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .io_arb (arb)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          src_cnt [NUM_IN];
    int          src_len [NUM_IN];
    int          src_seq [NUM_IN];
    logic [63:0] src_base[NUM_IN];
    int          log_id[$];
    logic [63:0] log_data[$];
    logic        log_last[$];
    int          vld_cycles;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < NUM_IN; i++) begin
            arb.in_tvalid[i]         = (src_cnt[i] > 0);
            arb.in_tlast[i]          = (((src_seq[i] + 1) % src_len[i]) == 0);
            arb.in_tdata[64*i +: 64] = src_base[i] + 64'(src_seq[i]);
        end
    endtask

    // Sample handshakes on the falling edge, advance sources just after the rising edge.
    task automatic tick();
        logic [NUM_IN-1:0] xfer;
        @(negedge aclk);
        xfer = arb.in_tvalid & arb.in_tready;
        if (arb.out_hs_ap_vld) begin
            vld_cycles++;
            if (arb.out_hs_ap_ack) begin
                log_id.push_back(int'(arb.out_id));
                log_data.push_back(arb.out_hs);
                log_last.push_back(arb.out_last);
            end
        end
        @(posedge aclk);
        #1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (xfer[i]) begin
                src_seq[i]++;
                src_cnt[i]--;
            end
        end
        drive_srcs();
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < NUM_IN; i++) begin
            src_cnt[i]  = 0;
            src_len[i]  = 1;
            src_seq[i]  = 0;
            src_base[i] = 64'h0;
        end
    endtask

    task automatic reset_dut();
        aresetn = 1'b0;
        arb.out_hs_ap_ack = 1'b0;
        clear_srcs();
        drive_srcs();
        tick();
        tick();
        aresetn = 1'b1;
        log_id.delete();
        log_data.delete();
        log_last.delete();
        vld_cycles = 0;
    endtask

    function automatic int id_at(input int k);
        return (k < log_id.size()) ? log_id[k] : 255;
    endfunction

    function automatic logic [63:0] data_at(input int k);
        return (k < log_data.size()) ? log_data[k] : 64'hDEAD;
    endfunction

    function automatic logic last_at(input int k);
        return (k < log_last.size()) ? log_last[k] : 1'bx;
    endfunction

    initial begin
        int rr_exp[6];
        int lk_exp[5];
        int lk_n;
        int lk_last_idx;

        // Reset values, with every requester valid while aresetn is low
        aresetn = 1'b0;
        arb.out_hs_ap_ack = 1'b0;
        vld_cycles = 0;
        clear_srcs();
        for (int i = 0; i < NUM_IN; i++) src_cnt[i] = 1;
        drive_srcs();
        tick();
        tick();
        check("rst_tready", 64'(arb.in_tready), 64'h0);
        check("rst_vld", 64'(arb.out_hs_ap_vld), 64'h0);
        check("rst_hs", arb.out_hs, 64'h0);
        check("rst_id", 64'(arb.out_id), 64'h0);
        check("rst_last", 64'(arb.out_last), 64'h0);

        // Single requester 2, ack tied high
        reset_dut();
        src_base[2] = 64'hA5A5_0000_0000_0001;
        src_cnt[2]  = 1;
        arb.out_hs_ap_ack = 1'b1;
        drive_srcs();
        #2;
        check("single_tready", 64'(arb.in_tready), 64'h4);
        repeat (8) tick();
        check("single_count", 64'(log_id.size()), 64'd1);
        check("single_hs", data_at(0), 64'hA5A5_0000_0000_0001);
        check("single_id", 64'(id_at(0)), 64'd2);
        check("single_last", 64'(last_at(0)), 64'd1);
        check("single_vld_cycles", 64'(vld_cycles), 64'd1);

        // Round-robin from reset across 0, 1, 3 with wrap-around
        reset_dut();
        src_base[0] = 64'h1000; src_cnt[0] = 100;
        src_base[1] = 64'h2000; src_cnt[1] = 100;
        src_base[3] = 64'h3000; src_cnt[3] = 100;
        arb.out_hs_ap_ack = 1'b1;
        drive_srcs();
        repeat (13) tick();
        rr_exp = '{0, 1, 3, 0, 1, 3};
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rr_id%0d", k), 64'(id_at(k)), 64'(rr_exp[k]));
        end
        check("rr_data3", data_at(3), 64'h1001);
        check("rr_data5", data_at(5), 64'h3001);

        // Packet from requester 1 competing with requester 0; last_grant primed to 0
        reset_dut();
        src_base[0] = 64'h4000; src_cnt[0] = 1;
        arb.out_hs_ap_ack = 1'b1;
        drive_srcs();
        repeat (4) tick();
        log_id.delete();
        log_data.delete();
        log_last.delete();
        src_cnt[0]  = 100;
        src_base[1] = 64'h5000; src_cnt[1] = 3; src_len[1] = 3;
        drive_srcs();
        repeat (14) tick();
`ifdef HS_ARB_PKT_LOCK_EN
        lk_exp = '{1, 1, 1, 0, 0};
        lk_n = 4;
        lk_last_idx = 2;
`else
        lk_exp = '{1, 0, 1, 0, 1};
        lk_n = 5;
        lk_last_idx = 4;
`endif
        for (int k = 0; k < lk_n; k++) begin
            check($sformatf("lock_id%0d", k), 64'(id_at(k)), 64'(lk_exp[k]));
        end
        check("lock_pkt_end_data", data_at(lk_last_idx), 64'h5002);
        check("lock_pkt_end_last", 64'(last_at(lk_last_idx)), 64'd1);
        check("lock_pkt_mid_last", 64'(last_at(0)), 64'd0);

        // Back-pressure: ack low for 5 cycles with another requester waiting
        reset_dut();
        src_base[3] = 64'hBEEF_0000_0000_0033; src_cnt[3] = 1;
        drive_srcs();
        tick();
        src_base[0] = 64'h6000; src_cnt[0] = 1;
        drive_srcs();
        for (int c = 0; c < 5; c++) begin
            #2;
            check($sformatf("bp_vld%0d", c), 64'(arb.out_hs_ap_vld), 64'd1);
            check($sformatf("bp_tready%0d", c), 64'(arb.in_tready), 64'h0);
            check($sformatf("bp_hs%0d", c), arb.out_hs, 64'hBEEF_0000_0000_0033);
            check($sformatf("bp_id%0d", c), 64'(arb.out_id), 64'd3);
            check($sformatf("bp_last%0d", c), 64'(arb.out_last), 64'd1);
            tick();
        end
        arb.out_hs_ap_ack = 1'b1;
        tick();
        arb.out_hs_ap_ack = 1'b0;
        repeat (3) tick();
        check("bp_count", 64'(log_id.size()), 64'd1);
        check("bp_acc_id", 64'(id_at(0)), 64'd3);
        check("bp_next_id", 64'(arb.out_id), 64'd0);
        check("bp_next_vld", 64'(arb.out_hs_ap_vld), 64'd1);

        // Reset pulse while a word from requester 0 awaits ack
        reset_dut();
        src_base[0] = 64'h7000; src_cnt[0] = 1;
        drive_srcs();
        tick();
        tick();
        check("mid_pre_vld", 64'(arb.out_hs_ap_vld), 64'd1);
        aresetn = 1'b0;
        src_cnt[0] = 1;
        src_base[1] = 64'h8000; src_cnt[1] = 1;
        drive_srcs();
        #2;
        check("mid_rst_tready", 64'(arb.in_tready), 64'h0);
        tick();
        check("mid_vld", 64'(arb.out_hs_ap_vld), 64'd0);
        check("mid_hs", arb.out_hs, 64'h0);
        aresetn = 1'b1;
        tick();
        check("mid_next_id", 64'(arb.out_id), 64'd0);
        check("mid_next_hs", arb.out_hs, 64'h7001);
        check("mid_next_vld", 64'(arb.out_hs_ap_vld), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
